// File: rtl/sprite_blitter.sv
// sprite_blitter: pipelined indexed-sprite renderer for the VGA pixel path.
// Draws a SPRITE_W x SPRITE_H sprite with power-of-two scaling, 90-degree
// rotations and a transparent index over a per-pixel background colour.
// It also flags per-frame collisions with other opaque objects.
// Ports:
//   vga_clk, reset                  pixel clock, async active-high reset
//   DrawX, DrawY, blank             current pixel coordinate / visible flag
//   pos_x, pos_y, rot, sprite_en    sprite placement (latched once per frame)
//   bg_red/green/blue, other_opaque background colour and foreign opacity
//   rom_address / rom_q             external synchronous texture ROM
//   pal_index / pal_red/green/blue  external combinational palette
//   red, green, blue, opaque        registered composited pixel (3-cycle latency)
//   collision                       previous frame saw an overlap
module sprite_blitter #(
  parameter int unsigned SPRITE_W    = 32,
  parameter int unsigned SPRITE_H    = 32,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned TRANSPARENT = 0,
  parameter int unsigned V_ACTIVE    = 480
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        rot,
  input  logic              sprite_en,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  input  logic              other_opaque,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque,
  output logic              collision
);

  localparam int unsigned SPAN_X = SPRITE_W << SCALE_SHIFT;
  localparam int unsigned SPAN_Y = SPRITE_H << SCALE_SHIFT;
  localparam bit          SQUARE = (SPRITE_W == SPRITE_H);
  localparam logic [9:0]  W_M1   = 10'(SPRITE_W - 1);
  localparam logic [9:0]  H_M1   = 10'(SPRITE_H - 1);

  // Shadow copies of the placement, loaded once per frame
  logic [9:0] px, py;
  logic [1:0] rot_s;
  logic       en_s;

  // Stage 1 / stage 2 sideband
  logic        hit1, blank1, oo1;
  logic [11:0] bg1;
  logic        hit2, blank2, oo2;
  logic [11:0] bg2;

  logic        coll_acc;

  logic               frame_latch_c;
  logic signed [10:0] dx_c, dy_c;
  logic               hit_c;
  logic [9:0]         u_c, v_c, col_c, row_c;
  logic [1:0]         rot_eff_c;
  logic [ADDR_W-1:0]  addr_c;
  logic               drawn_c;
  logic               coll_set_c;

  assign frame_latch_c = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
  assign pal_index     = rom_q;

  // Offset from the sprite origin; sign bit marks pixels left/above the sprite
  assign dx_c = $signed({1'b0, DrawX}) - $signed({1'b0, px});
  assign dy_c = $signed({1'b0, DrawY}) - $signed({1'b0, py});

  assign hit_c = en_s && !dx_c[10] && !dy_c[10] &&
                 (32'(dx_c[9:0]) < SPAN_X) && (32'(dy_c[9:0]) < SPAN_Y);

  assign u_c = dx_c[9:0] >> SCALE_SHIFT;
  assign v_c = dy_c[9:0] >> SCALE_SHIFT;

  // Quarter turns only make sense for square sprites; otherwise fall back to 0
  assign rot_eff_c = (!SQUARE && rot_s[0]) ? 2'd0 : rot_s;

  // Screen texel (u,v) -> source texel (col,row)
  always_comb begin
    col_c = u_c;
    row_c = v_c;
    case (rot_eff_c)
      2'd1: begin col_c = v_c;        row_c = W_M1 - u_c; end
      2'd2: begin col_c = W_M1 - u_c; row_c = H_M1 - v_c; end
      2'd3: begin col_c = H_M1 - v_c; row_c = u_c;        end
      default: ;
    endcase
  end

  assign addr_c = hit_c ? ADDR_W'(32'(row_c) * SPRITE_W + 32'(col_c)) : '0;

  assign drawn_c    = hit2 && (rom_q != IDX_W'(TRANSPARENT));
  assign coll_set_c = blank2 && drawn_c && oo2;

  // Frame latch of placement
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      px    <= '0;
      py    <= '0;
      rot_s <= '0;
      en_s  <= 1'b0;
    end else if (frame_latch_c) begin
      px    <= pos_x;
      py    <= pos_y;
      rot_s <= rot;
      en_s  <= sprite_en;
    end
  end

  // Stage 1 and 2: address generation and sideband alignment with the ROM
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      hit1        <= 1'b0;
      blank1      <= 1'b0;
      oo1         <= 1'b0;
      bg1         <= '0;
      hit2        <= 1'b0;
      blank2      <= 1'b0;
      oo2         <= 1'b0;
      bg2         <= '0;
    end else begin
      rom_address <= addr_c;
      hit1        <= hit_c;
      blank1      <= blank;
      oo1         <= other_opaque;
      bg1         <= {bg_red, bg_green, bg_blue};
      hit2        <= hit1;
      blank2      <= blank1;
      oo2         <= oo1;
      bg2         <= bg1;
    end
  end

  // Stage 3: composite over background
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      opaque <= 1'b0;
    end else begin
      if (!blank2) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else if (drawn_c) begin
        red   <= pal_red;
        green <= pal_green;
        blue  <= pal_blue;
      end else begin
        {red, green, blue} <= bg2;
      end
      opaque <= blank2 && drawn_c;
    end
  end

  // Collision: accumulate over a frame, publish at the frame latch
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      coll_acc  <= 1'b0;
      collision <= 1'b0;
    end else if (frame_latch_c) begin
      collision <= coll_acc | coll_set_c;
      coll_acc  <= 1'b0;
    end else if (coll_set_c) begin
      coll_acc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized bench for sprite_blitter: two instances (square 8x8 at 2x scale,
// non-square 8x4 at 1x) scanned over a small raster, checked every cycle
// against a frame-level model of what should be on screen.
module tb_sprite_blitter;

  localparam int V_ACT = 24;
  localparam int H_VIS = 32;
  localparam int V_VIS = 24;
  localparam int H_TOT = 40;
  localparam int V_TOT = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] draw_x, draw_y, pos_x, pos_y;
  logic       blank, sprite_en, other_opaque;
  logic [1:0] rot;
  logic [3:0] bg_r, bg_g, bg_b;

  logic [5:0] addr_a;
  logic [4:0] addr_b;
  logic [3:0] q_a = 4'd0, q_b = 4'd0;
  logic [3:0] pidx_a, pidx_b;
  logic [3:0] pr_a, pg_a, pb_a, pr_b, pg_b, pb_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       opq_a, opq_b, coll_a, coll_b;

  logic [3:0]  rom_a [64];
  logic [3:0]  rom_b [32];
  logic [11:0] palette [16];

  always_ff @(posedge clk) begin
    q_a <= rom_a[addr_a];
    q_b <= rom_b[addr_b];
  end
  assign {pr_a, pg_a, pb_a} = palette[pidx_a];
  assign {pr_b, pg_b, pb_b} = palette[pidx_b];

  sprite_blitter #(.SPRITE_W(8), .SPRITE_H(8), .SCALE_SHIFT(1), .ADDR_W(6),
                   .IDX_W(4), .TRANSPARENT(0), .V_ACTIVE(V_ACT)) dut_a (
    .vga_clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .rot(rot), .sprite_en(sprite_en),
    .bg_red(bg_r), .bg_green(bg_g), .bg_blue(bg_b), .other_opaque(other_opaque),
    .rom_address(addr_a), .rom_q(q_a), .pal_index(pidx_a),
    .pal_red(pr_a), .pal_green(pg_a), .pal_blue(pb_a),
    .red(r_a), .green(g_a), .blue(b_a), .opaque(opq_a), .collision(coll_a));

  sprite_blitter #(.SPRITE_W(8), .SPRITE_H(4), .SCALE_SHIFT(0), .ADDR_W(5),
                   .IDX_W(4), .TRANSPARENT(0), .V_ACTIVE(V_ACT)) dut_b (
    .vga_clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .rot(rot), .sprite_en(sprite_en),
    .bg_red(bg_r), .bg_green(bg_g), .bg_blue(bg_b), .other_opaque(other_opaque),
    .rom_address(addr_b), .rom_q(q_b), .pal_index(pidx_b),
    .pal_red(pr_b), .pal_green(pg_b), .pal_blue(pb_b),
    .red(r_b), .green(g_b), .blue(b_b), .opaque(opq_b), .collision(coll_b));

  typedef struct {
    logic [11:0] rgb_a;
    logic        opq_a;
    logic [11:0] rgb_b;
    logic        opq_b;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: placement as the sprite currently sees it
  int sh_x, sh_y, sh_rot;
  bit sh_en;
  bit acc_a, acc_b, coll_exp_a, coll_exp_b;
  bit oo_on;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ROM address of the texel under screen pixel (x,y), or -1 if not covered
  function automatic int tex_addr(input int w, input int h, input int s,
                                  input int x, input int y);
    int u, v, c, r, t;
    if (!sh_en || x < sh_x || y < sh_y) return -1;
    if (x - sh_x >= (w << s) || y - sh_y >= (h << s)) return -1;
    u = (x - sh_x) >> s;
    v = (y - sh_y) >> s;
    c = u;
    r = v;
    if (w == h) begin
      // each quarter turn CW: screen (c,r) reads source (r, w-1-c)
      for (int k = 0; k < sh_rot; k++) begin
        t = c;
        c = r;
        r = w - 1 - t;
      end
    end else if (sh_rot == 2) begin
      c = w - 1 - u;
      r = h - 1 - v;
    end
    return r * w + c;
  endfunction

  task automatic model_clear();
    exp_t z;
    z.rgb_a = '0; z.opq_a = 1'b0; z.rgb_b = '0; z.opq_b = 1'b0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
    sh_x = 0; sh_y = 0; sh_rot = 0; sh_en = 1'b0;
    acc_a = 1'b0; acc_b = 1'b0; coll_exp_a = 1'b0; coll_exp_b = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rgb_a"}, 32'({r_a, g_a, b_a}), 32'd0);
    check({tag, "_opq_a"}, 32'(opq_a), 32'd0);
    check({tag, "_coll_a"}, 32'(coll_a), 32'd0);
    check({tag, "_rgb_b"}, 32'({r_b, g_b, b_b}), 32'd0);
    check({tag, "_opq_b"}, 32'(opq_b), 32'd0);
    check({tag, "_coll_b"}, 32'(coll_b), 32'd0);
  endtask

  task automatic step(input int x, input int y);
    exp_t        e;
    int          aa, ab;
    bit          b, oo, da, db;
    logic [11:0] bg;
    b  = (x < H_VIS && y < V_VIS) && ($urandom_range(0, 15) != 0);
    oo = oo_on && ($urandom_range(0, 15) == 0);
    bg = 12'($urandom);
    draw_x = 10'(x);
    draw_y = 10'(y);
    blank  = b;
    other_opaque = oo;
    {bg_r, bg_g, bg_b} = bg;

    aa = tex_addr(8, 8, 1, x, y);
    ab = tex_addr(8, 4, 0, x, y);
    da = (aa >= 0) && (rom_a[aa] != 4'd0);
    db = (ab >= 0) && (rom_b[ab] != 4'd0);
    e.rgb_a = !b ? 12'd0 : (da ? palette[rom_a[aa]] : bg);
    e.opq_a = b && da;
    e.rgb_b = !b ? 12'd0 : (db ? palette[rom_b[ab]] : bg);
    e.opq_b = b && db;
    if (b && da && oo) acc_a = 1'b1;
    if (b && db && oo) acc_b = 1'b1;
    q.push_back(e);

    @(posedge clk);
    if (x == 0 && y == V_ACT) begin
      sh_x = int'(pos_x); sh_y = int'(pos_y); sh_rot = int'(rot); sh_en = sprite_en;
      coll_exp_a = acc_a; acc_a = 1'b0;
      coll_exp_b = acc_b; acc_b = 1'b0;
    end
    #1;
    if (q.size() >= 3) begin
      e = q.pop_front();
      check("rgb_a", 32'({r_a, g_a, b_a}), 32'(e.rgb_a));
      check("opq_a", 32'(opq_a), 32'(e.opq_a));
      check("rgb_b", 32'({r_b, g_b, b_b}), 32'(e.rgb_b));
      check("opq_b", 32'(opq_b), 32'(e.opq_b));
    end
    check("coll_a", 32'(coll_a), 32'(coll_exp_a));
    check("coll_b", 32'(coll_b), 32'(coll_exp_b));
  endtask

  initial begin
    foreach (rom_a[i]) rom_a[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    foreach (rom_b[i]) rom_b[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    foreach (palette[i]) palette[i] = 12'($urandom);
    reset = 1'b1;
    draw_x = '0; draw_y = '0; blank = 1'b0; other_opaque = 1'b0;
    pos_x = '0; pos_y = '0; rot = '0; sprite_en = 1'b1;
    {bg_r, bg_g, bg_b} = 12'd0;
    oo_on = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    model_clear();

    for (int f = 0; f < 10; f++) begin
      for (int y = 0; y < V_TOT; y++) begin
        for (int x = 0; x < H_TOT; x++) begin
          if (x == 1 && y == 0) begin
            pos_x     = 10'($urandom_range(0, 34));
            pos_y     = 10'($urandom_range(0, 26));
            rot       = 2'(f % 4);
            sprite_en = (f % 5 != 3);
            oo_on     = (f % 3 != 2);
          end
          // mid-frame move: must not affect the frame being drawn
          if (x == 5 && y == 10) begin
            pos_x = 10'($urandom_range(0, 34));
            pos_y = 10'($urandom_range(0, 26));
          end
          step(x, y);
          if (f == 5 && y == 6 && x == 10) begin
            reset = 1'b1;
            #2;
            check_zero("midreset");
            @(negedge clk);
            reset = 1'b0;
            model_clear();
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
